// File: rtl/pip_mem_stage.sv
// MEM stage of the 5-stage core.
// Takes the EX/MEM pipeline register contents and drives a variable-latency data
// memory over a req/ack handshake. It stalls upstream while an access is in
// flight and registers the MEM/WB fields that feed the register-file write port.
// A memory that never acks is abandoned after TIMEOUT wait cycles. In that case
// the sticky err flag is raised and the load data is taken as zero.
module pip_mem_stage #(
  parameter int DW      = 16,  // data width
  parameter int IW      = 16,  // PC width
  parameter int AW      = 8,   // data-memory address width
  parameter int TIMEOUT = 15   // wait cycles without ack before abort (1..255)
) (
  input  logic          clk,
  input  logic          rst,
  // EX/MEM pipeline register
  input  logic [3:0]    w_addr_in,
  input  logic [DW-1:0] w_data_in,
  input  logic [DW-1:0] Rdata2_in,
  input  logic          memWrite_in,
  input  logic          memRead_in,
  input  logic          memToReg_in,
  input  logic          wen_in,
  input  logic          jal_in,
  input  logic [IW-1:0] PC_in,
  // data memory handshake
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  // pipeline control
  output logic          stall_out,
  // MEM/WB pipeline register
  output logic [3:0]    wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          wb_wen,
  output logic          err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // The counter is 8 bits wide because TIMEOUT may be as large as 255.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t        state_reg;
  logic [7:0]    cnt_reg;

  // Instruction fields captured when the access is issued.
  // The upstream stages may change their inputs at the ack edge, so these are kept locally.
  logic [3:0]    cap_waddr_reg;
  logic          cap_wen_reg;
  logic          cap_m2r_reg;
  logic          cap_jal_reg;
  logic [IW-1:0] cap_pc_reg;
  logic [DW-1:0] cap_alu_reg;

  logic          mem_op;
  logic          in_wait;
  logic          timeout_hit;
  logic          access_done;
  logic [IW-1:0] pc_inc_in;
  logic [IW-1:0] pc_inc_cap;
  logic [DW-1:0] pc_ext_in;
  logic [DW-1:0] pc_ext_cap;
  logic [DW-1:0] load_data;
  logic [DW-1:0] wb_data_pass;
  logic [DW-1:0] wb_data_done;

  assign mem_op  = memRead_in | memWrite_in;
  assign in_wait = (state_reg == ST_WAIT);

  // Return address for jal. The addition wraps modulo 2^IW.
  assign pc_inc_in  = PC_in + IW'(1);
  assign pc_inc_cap = cap_pc_reg + IW'(1);

  // The return PC is zero-extended into the data width.
  // It is truncated if the PC happens to be wider than the data width.
  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_pc_ext
      if (gi < IW) begin : g_bit
        assign pc_ext_in[gi]  = pc_inc_in[gi];
        assign pc_ext_cap[gi] = pc_inc_cap[gi];
      end else begin : g_zero
        assign pc_ext_in[gi]  = 1'b0;
        assign pc_ext_cap[gi] = 1'b0;
      end
    end
  endgenerate

  // The timeout fires only when no ack arrives in the last allowed cycle.
  // An ack arriving in that same cycle still wins.
  assign timeout_hit = in_wait & ~dmem_ack & (cnt_reg == TIMEOUT_CNT);
  assign access_done = in_wait & (dmem_ack | timeout_hit);

  // An aborted load returns zero rather than whatever is on the read bus.
  assign load_data = dmem_ack ? dmem_rdata : '0;

  assign wb_data_pass = jal_in      ? pc_ext_in  : w_data_in;
  assign wb_data_done = cap_jal_reg ? pc_ext_cap :
                        cap_m2r_reg ? load_data  : cap_alu_reg;

  // Stall upstream on the issue cycle and on every wait cycle that does not complete the access.
  always_comb begin
    stall_out = 1'b0;
    case (state_reg)
      ST_IDLE: stall_out = mem_op;
      ST_WAIT: stall_out = ~access_done;
      default: stall_out = 1'b0;
    endcase
  end

  // Handshake FSM together with the registered memory outputs and the MEM/WB outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      wb_addr       <= '0;
      wb_data       <= '0;
      wb_wen        <= 1'b0;
      err           <= 1'b0;
      cap_waddr_reg <= '0;
      cap_wen_reg   <= 1'b0;
      cap_m2r_reg   <= 1'b0;
      cap_jal_reg   <= 1'b0;
      cap_pc_reg    <= '0;
      cap_alu_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (mem_op) begin
            // Issue the access. If both read and write are set, the store wins.
            dmem_req      <= 1'b1;
            dmem_we       <= memWrite_in;
            dmem_addr     <= w_data_in[AW-1:0];
            dmem_wdata    <= Rdata2_in;
            cap_waddr_reg <= w_addr_in;
            cap_wen_reg   <= wen_in;
            cap_m2r_reg   <= memToReg_in;
            cap_jal_reg   <= jal_in;
            cap_pc_reg    <= PC_in;
            cap_alu_reg   <= w_data_in;
            wb_wen        <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= ST_WAIT;
          end else begin
            // Non-memory instruction: pass straight through to MEM/WB.
            wb_addr <= w_addr_in;
            wb_data <= wb_data_pass;
            wb_wen  <= wen_in;
          end
        end
        ST_WAIT: begin
          if (access_done) begin
            dmem_req  <= 1'b0;
            wb_addr   <= cap_waddr_reg;
            wb_data   <= wb_data_done;
            wb_wen    <= cap_wen_reg;
            state_reg <= ST_IDLE;
            if (timeout_hit) begin
              err <= 1'b1;
            end
          end else begin
            // The request lines hold their values.
            // MEM/WB carries a bubble until the access completes.
            wb_wen  <= 1'b0;
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pip_mem_stage.sv
// Scoreboard bench for pip_mem_stage.
// The expected MEM/WB writes are queued when an instruction is driven.
// They are compared whenever the DUT raises wb_wen.
module tb_pip_mem_stage;

  localparam int DW      = 16;
  localparam int IW      = 16;
  localparam int AW      = 8;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    w_addr_in;
  logic [DW-1:0] w_data_in;
  logic [DW-1:0] Rdata2_in;
  logic          memWrite_in;
  logic          memRead_in;
  logic          memToReg_in;
  logic          wen_in;
  logic          jal_in;
  logic [IW-1:0] PC_in;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ack;
  logic          stall_out;
  logic [3:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_wen;
  logic          err;

  typedef struct packed {
    logic [3:0]    a;
    logic [DW-1:0] d;
  } wb_t;

  wb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  pip_mem_stage #(.DW(DW), .IW(IW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .w_addr_in   (w_addr_in),
    .w_data_in   (w_data_in),
    .Rdata2_in   (Rdata2_in),
    .memWrite_in (memWrite_in),
    .memRead_in  (memRead_in),
    .memToReg_in (memToReg_in),
    .wen_in      (wen_in),
    .jal_in      (jal_in),
    .PC_in       (PC_in),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .stall_out   (stall_out),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_wen      (wb_wen),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every register-file write must match the oldest expectation.
  always @(negedge clk) begin
    if (wb_wen) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'(wb_wen), 32'd0);
      end else begin
        wb_t e;
        e = sb.pop_front();
        chk("wb_addr", 32'(wb_addr), 32'(e.a));
        chk("wb_data", 32'(wb_data), 32'(e.d));
        $display("wb write addr=%0d data=%h (exp %0d/%h)", wb_addr, wb_data, e.a, e.d);
      end
    end
  end

  task automatic drive_idle();
    w_addr_in   = '0;
    w_data_in   = '0;
    Rdata2_in   = '0;
    memWrite_in = 1'b0;
    memRead_in  = 1'b0;
    memToReg_in = 1'b0;
    wen_in      = 1'b0;
    jal_in      = 1'b0;
    PC_in       = '0;
  endtask

  // Pass-through instruction. It is called at a negedge and returns at the next negedge.
  task automatic alu_op(input logic [3:0] wa, input logic [DW-1:0] alu, input logic wen,
                        input logic jal, input logic [IW-1:0] pc);
    wb_t e;
    logic [IW-1:0] pc1;
    drive_idle();
    w_addr_in = wa; w_data_in = alu; wen_in = wen; jal_in = jal; PC_in = pc;
    #1;
    chk("alu_stall", 32'(stall_out), 32'd0);
    pc1 = pc + 16'd1;
    e.a = wa;
    e.d = jal ? pc1 : alu;
    if (wen) sb.push_back(e);
    $display("alu op wa=%0d alu=%h jal=%0d pc=%h", wa, alu, jal, pc);
    @(negedge clk);
  endtask

  // Load or store.
  // The DUT sees wait_cycles cycles without an ack after the request is visible.
  // Then it sees either an ack (give_ack=1) or nothing (give_ack=0, for the timeout case).
  task automatic mem_access(input logic ld, input logic st, input logic [3:0] wa,
                            input logic [DW-1:0] alu, input logic [DW-1:0] rd2,
                            input logic wen, input logic m2r, input logic jal,
                            input logic [IW-1:0] pc, input int wait_cycles,
                            input logic give_ack, input logic [DW-1:0] rdata);
    int stalls;
    wb_t e;
    logic [IW-1:0] pc1;
    stalls = 0;
    drive_idle();
    memRead_in = ld; memWrite_in = st; w_addr_in = wa; w_data_in = alu; Rdata2_in = rd2;
    wen_in = wen; memToReg_in = m2r; jal_in = jal; PC_in = pc;
    #1;
    if (stall_out) stalls++;
    @(negedge clk);
    chk("req_issue", 32'(dmem_req), 32'd1);
    chk("we_issue", 32'(dmem_we), 32'(st));
    chk("addr_issue", 32'(dmem_addr), 32'(alu[AW-1:0]));
    if (st) chk("wdata_issue", 32'(dmem_wdata), 32'(rd2));
    for (int k = 0; k < wait_cycles; k++) begin
      dmem_rdata = 16'hDEAD;
      #1;
      if (stall_out) stalls++;
      @(negedge clk);
      chk("req_hold", 32'(dmem_req), 32'd1);
      chk("addr_hold", 32'(dmem_addr), 32'(alu[AW-1:0]));
      if (st) chk("wdata_hold", 32'(dmem_wdata), 32'(rd2));
    end
    dmem_ack   = give_ack;
    dmem_rdata = give_ack ? rdata : 16'hDEAD;
    #1;
    chk("stall_end", 32'(stall_out), 32'd0);
    chk("stall_count", 32'(stalls), 32'(wait_cycles + 1));
    pc1 = pc + 16'd1;
    e.a = wa;
    e.d = jal ? pc1 : (m2r ? (give_ack ? rdata : 16'h0000) : alu);
    if (wen) sb.push_back(e);
    $display("mem op ld=%0d st=%0d addr=%h waits=%0d ack=%0d stalls=%0d",
             ld, st, alu[AW-1:0], wait_cycles, give_ack, stalls);
    @(negedge clk);
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    drive_idle();
    chk("req_drop", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    drive_idle();
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", 32'(dmem_addr), 32'd0);
    chk("rst_wdata", 32'(dmem_wdata), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_wb_wen", 32'(wb_wen), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Pass-through, including jal and PC wrap.
    alu_op(4'd3, 16'h1234, 1'b1, 1'b0, 16'h0000);
    alu_op(4'd5, 16'h7777, 1'b1, 1'b1, 16'h00FF);
    alu_op(4'd6, 16'h8888, 1'b1, 1'b1, 16'hFFFF);
    alu_op(4'd7, 16'h9999, 1'b0, 1'b0, 16'h0000);

    // A stray ack while idle must not disturb anything.
    dmem_ack = 1'b1;
    dmem_rdata = 16'h4321;
    alu_op(4'd8, 16'h0042, 1'b1, 1'b0, 16'h0000);
    dmem_ack = 1'b0;
    chk("idle_ack_req", 32'(dmem_req), 32'd0);

    // Load, ack three cycles after the request.
    mem_access(1'b1, 1'b0, 4'd9, 16'h0010, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 3, 1'b1, 16'hBEEF);
    // Store, ack after one cycle.
    mem_access(1'b0, 1'b1, 4'd2, 16'h0020, 16'h00AA, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0000);
    // Minimum-latency load followed directly by an ALU op.
    mem_access(1'b1, 1'b0, 4'd4, 16'h0033, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 16'hCAFE);
    alu_op(4'd1, 16'h0101, 1'b1, 1'b0, 16'h0000);
    // Read and write together: the store wins and the ALU value is written back.
    mem_access(1'b1, 1'b1, 4'd11, 16'h0144, 16'h5A5A, 1'b1, 1'b0, 1'b0, 16'h0000, 2, 1'b1, 16'h1111);
    // jal together with a load: the return PC wins.
    mem_access(1'b1, 1'b0, 4'd12, 16'h0050, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0200, 1, 1'b1, 16'h2222);
    chk("err_before_to", 32'(err), 32'd0);

    // Timeout: the ack never comes.
    mem_access(1'b1, 1'b0, 4'd13, 16'h0060, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, TIMEOUT, 1'b0, 16'h0000);
    chk("err_after_to", 32'(err), 32'd1);
    alu_op(4'd14, 16'hABCD, 1'b1, 1'b0, 16'h0000);
    chk("err_sticky", 32'(err), 32'd1);

    // Reset in WAIT, followed by a late ack.
    drive_idle();
    memRead_in = 1'b1; w_addr_in = 4'd10; w_data_in = 16'h0030; wen_in = 1'b1; memToReg_in = 1'b1;
    @(negedge clk);
    chk("rstw_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    dmem_ack = 1'b1;
    dmem_rdata = 16'h5555;
    #1;
    chk("rstw_req_low", 32'(dmem_req), 32'd0);
    chk("rstw_stall", 32'(stall_out), 32'd0);
    chk("rstw_err", 32'(err), 32'd0);
    chk("rstw_wen", 32'(wb_wen), 32'd0);
    $display("reset in wait, late ack pulsed");
    @(negedge clk);
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    chk("rstw_req_after", 32'(dmem_req), 32'd0);
    chk("rstw_wen_after", 32'(wb_wen), 32'd0);
    mem_access(1'b1, 1'b0, 4'd15, 16'h0070, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1, 1'b1, 16'h7E57);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
